data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Word-addressed 16-bit data memory that serves the CPU's load/store port with fixed multi-cycle latency. It answers the request/response interface the datapath drives for LW/SW. Accepts one request per cycle, is fully pipelined, and returns read data (and optionally write acknowledgements) in request order. It sits between the CPU's memory stage and the backing storage array.

## Interface

- DEPTH_LOG2, 10 — log2 of memory depth in 16-bit words (1024 words).
- LATENCY, 4 — cycles from request acceptance to response; legal range 1..8.
- clk  in  1  — single clock; all state updates on rising edge.
- rst  in  1  — reset, synchronous and active-high.
- req_valid  in  1  — request present this cycle.
- req_ready  out  1  — responder can accept; handshake completes when req_valid & req_ready.
- req_wr  in  1  — 1 = store (SW), 0 = load (LW).
- req_addr  in  16  — byte address.
- req_wdata  in  16  — store data.
- rsp_valid  out  1  — response present this cycle; single-cycle pulse per response, no backpressure.
- rsp_wr  out  1  — response corresponds to a store.
- rsp_data  out  16  — load data (or echoed store data, see Configuration); 0 when rsp_valid low.
- busy  out  1  — at least one request in flight.
- outstanding  out  4  — count of requests in flight (0..LATENCY).

## Operation

- Word index = req_addr[DEPTH_LOG2:1]; req_addr[0] ignored (aligned access); bits above DEPTH_LOG2 ignored (aliasing/wrap).
- Store: array word written at the acceptance edge with req_wdata.
- Load: array word sampled at the acceptance edge; the value travels down the latency pipe. A store accepted after a load, but before that load's response, does not alter it. A load accepted the cycle after a store to the same word returns the new value.
- Latency pipe: LATENCY stages, each holding {valid, wr, data}. Shifts every cycle unconditionally; the final stage drives rsp_*.
- req_ready = !rst. No other stall source; throughput one request per cycle.
- outstanding increments on acceptance and decrements on a response-stage exit; both in the same cycle leave it unchanged. busy = (outstanding != 0).
- Memory array contents are not cleared by rst.

## Timing

- Request accepted in cycle N (handshake true before edge N) → rsp_valid high in cycle N+LATENCY. LATENCY=1 gives a response in the cycle immediately after acceptance.
- Back-to-back requests in cycles N, N+1, N+2 → responses in N+L, N+L+1, N+L+2, same order.
- Reset values: req_ready=0 while rst high; rsp_valid=0, rsp_wr=0, rsp_data=0, busy=0, outstanding=0.
- Reset mid-operation: all pipe valid bits cleared at the reset edge and in-flight responses are dropped. Stores already accepted remain committed in the array. A request presented during reset is not accepted.
- First acceptance possible in the first cycle after rst deasserts.

## Configuration

- MEM_WRITE_ACK_EN defined: stores produce a response after LATENCY cycles with rsp_wr=1 and rsp_data=stored value. outstanding counts stores.
- Undefined: stores produce no response. Their pipe stage is injected with valid=0, rsp_wr is constant 0, and outstanding/busy count loads only.

## Structure

- Shared package mem_pkg: DEFAULT_LATENCY, DEFAULT_DEPTH_LOG2, MAX_LATENCY=8, word width constant (16), and the pipe-stage struct typedef {valid, wr, data}.
- One sub-module, mem_lat_pipe: parameterised LATENCY-deep shift register of stage structs with synchronous clear. The top level holds the array, index decode, handshake and outstanding counter.

## Test plan

- Reset then idle: rst high 3 cycles → req_ready=0, rsp_valid=0, outstanding=0; cycle after release req_ready=1.
- Store 0xBEEF to addr 0x0010, next cycle load 0x0010 (LATENCY=4) → rsp_valid in cycle of load+4, rsp_data=0xBEEF, rsp_wr=0. With MEM_WRITE_ACK_EN, an extra response one cycle earlier with rsp_wr=1, data 0xBEEF.
- Ordering: load 0x0020 (holds 0x1111), next cycle store 0x2222 to 0x0020 → load response returns 0x1111; a subsequent load returns 0x2222.
- Streaming: 8 back-to-back loads of addrs 0x0000..0x000E (preloaded 0..7) → 8 consecutive rsp_valid cycles with data 0..7; outstanding peaks at 4.
- Aliasing/alignment: store 0xAAAA to 0x0801, load 0x0000 (DEPTH_LOG2=10) → returns 0xAAAA.
- Reset mid-flight: issue 3 loads, assert rst 1 cycle after the third → no rsp_valid afterwards, outstanding=0. A store accepted before the reset is visible to a later load.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and latency-pipe stage type for data_mem_responder
package mem_pkg;

    localparam int DEFAULT_LATENCY    = 4;
    localparam int DEFAULT_DEPTH_LOG2 = 10;
    localparam int MAX_LATENCY        = 8;
    localparam int WORD_W             = 16;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [WORD_W-1:0] data;
    } pipe_stage_t;

    localparam int STAGE_W = $bits(pipe_stage_t);

endpackage

// File: rtl/mem_lat_pipe.sv
// rtl/mem_lat_pipe.sv - LATENCY-deep response shift register with synchronous clear
module mem_lat_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [STAGE_W-1:0] stage_i,
    output logic [STAGE_W-1:0] stage_o
);

    pipe_stage_t stages_q [LATENCY];

    // Shifts every cycle; there is no backpressure on the response side.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages_q[i] <= '0;
            end
        end else begin
            stages_q[0] <= pipe_stage_t'(stage_i);
            for (int i = 1; i < LATENCY; i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign stage_o = stages_q[LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency pipelined 16-bit data memory; MEM_WRITE_ACK_EN enables store responses
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_wr,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic [3:0]  outstanding
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  accept;
    pipe_stage_t           in_stage;
    pipe_stage_t           out_stage;
    logic [3:0]            outstanding_q;
    logic [3:0]            outstanding_d;
    logic                  unused_bits;

    assign req_ready = !rst;
    assign accept    = req_valid && req_ready;
    // Byte address in, word index out; high bits alias and bit 0 is dropped.
    assign word_idx  = req_addr[DEPTH_LOG2:1];

    // The array is never reset so committed stores survive rst.
    always_ff @(posedge clk) begin
        if (accept && req_wr) begin
            mem_q[word_idx] <= req_wdata;
        end
    end

    always_comb begin
        in_stage = '0;
`ifdef MEM_WRITE_ACK_EN
        in_stage.valid = accept;
        in_stage.wr    = req_wr;
        in_stage.data  = req_wr ? req_wdata : mem_q[word_idx];
`else
        in_stage.valid = accept && !req_wr;
        in_stage.data  = mem_q[word_idx];
`endif
    end

    mem_lat_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .clr     (rst),
        .stage_i (in_stage),
        .stage_o (out_stage)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        if (in_stage.valid && !out_stage.valid) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!in_stage.valid && out_stage.valid) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign rsp_valid   = out_stage.valid;
    assign rsp_data    = out_stage.valid ? out_stage.data : '0;
`ifdef MEM_WRITE_ACK_EN
    assign rsp_wr      = out_stage.valid && out_stage.wr;
`else
    assign rsp_wr      = 1'b0;
`endif
    assign outstanding = outstanding_q;
    assign busy        = (outstanding_q != 4'd0);

    assign unused_bits = ^{req_addr[15:DEPTH_LOG2+1], req_addr[0], out_stage.wr};

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int LAT = 4;
    localparam int DL2 = 10;
`ifdef MEM_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_wr;
    logic [15:0] rsp_data;
    logic        busy;
    logic [3:0]  outstanding;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_LOG2 (DL2),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_wr      (rsp_wr),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .outstanding (outstanding)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference: every accepted request becomes an expected response due at a cycle number.
    typedef struct {
        int          due;
        bit          wr;
        logic [15:0] data;
        bit          known;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_mem   [0:1023];
    bit          m_known [0:1023];

    typedef struct {
        bit          v;
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        bit          ev;
        bit          ew;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic apply(input bit r, input bit v, input bit w, input logic [15:0] a, input logic [15:0] d);
        int   idx;
        exp_t e;
        bit   exp_v;
        rst       = r;
        req_valid = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        edge_n++;
        if (r) begin
            q.delete();
        end else begin
            if (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
            if (v) begin
                idx     = (int'(a) >> 1) % 1024;
                e.due   = edge_n + LAT - 1;
                e.wr    = w;
                e.known = 1'b1;
                if (w) begin
                    e.data       = d;
                    m_mem[idx]   = d;
                    m_known[idx] = 1'b1;
                    if (ACK) q.push_back(e);
                end else begin
                    e.data  = m_mem[idx];
                    e.known = m_known[idx];
                    q.push_back(e);
                end
            end
        end
        #1;
        exp_v = (q.size() > 0) && (q[0].due == edge_n);
        chk("req_ready", {31'd0, req_ready}, {31'd0, !r});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
        if (exp_v) begin
            chk("rsp_wr", {31'd0, rsp_wr}, {31'd0, q[0].wr});
            if (q[0].known) chk("rsp_data", {16'd0, rsp_data}, {16'd0, q[0].data});
        end else begin
            chk("rsp_wr_idle", {31'd0, rsp_wr}, 32'd0);
            chk("rsp_data_idle", {16'd0, rsp_data}, 32'd0);
        end
        chk("outstanding", {28'd0, outstanding}, q.size());
        chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    int          got_n;
    int          first_c;
    int          last_c;
    int          peak;
    logic [15:0] got [16];
    int          widx;
    logic [15:0] waddr;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;

        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(1);

        apply(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1111);
        idle(6);

        // Rows assume LATENCY = 4: a request in row k responds in row k+3.
        tbl[0] = '{1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0};
        tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0,    1'b0, 1'b0, 16'h0};
        tbl[2] = '{1'b1, 1'b0, 16'h0020, 16'h0,    1'b0, 1'b0, 16'h0};
        tbl[3] = '{1'b1, 1'b1, 16'h0020, 16'h2222, 1'b0, 1'b0, 16'h0};
        tbl[4] = '{1'b1, 1'b0, 16'h0020, 16'h0,    1'b1, 1'b0, 16'hBEEF};
        tbl[5] = '{1'b1, 1'b1, 16'h0801, 16'hAAAA, 1'b1, 1'b0, 16'h1111};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 16'h0,    1'b0, 1'b0, 16'h0};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 16'h0,    1'b1, 1'b0, 16'h2222};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0,    1'b0, 1'b0, 16'h0};
        tbl[9] = '{1'b0, 1'b0, 16'h0000, 16'h0,    1'b1, 1'b0, 16'hAAAA};
        if (ACK) begin
            tbl[3].ev = 1'b1; tbl[3].ew = 1'b1; tbl[3].ed = 16'hBEEF;
            tbl[6].ev = 1'b1; tbl[6].ew = 1'b1; tbl[6].ed = 16'h2222;
            tbl[8].ev = 1'b1; tbl[8].ew = 1'b1; tbl[8].ed = 16'hAAAA;
        end
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), {31'd0, rsp_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_wr", i), {31'd0, rsp_wr}, {31'd0, tbl[i].ew});
            chk($sformatf("tbl%0d_data", i), {16'd0, rsp_data}, {16'd0, tbl[i].ed});
        end
        idle(6);

        for (int i = 0; i < 8; i++) apply(1'b0, 1'b1, 1'b1, 16'(i * 2), 16'(i));
        idle(6);
        got_n = 0; first_c = -1; last_c = -1; peak = 0;
        for (int i = 0; i < 14; i++) begin
            apply(1'b0, i < 8, 1'b0, 16'(i * 2), 16'h0);
            if (int'(outstanding) > peak) peak = int'(outstanding);
            if (rsp_valid === 1'b1) begin
                if (got_n < 16) got[got_n] = rsp_data;
                if (first_c < 0) first_c = edge_n;
                last_c = edge_n;
                got_n++;
            end
        end
        chk("stream_count", got_n, 8);
        chk("stream_contig", last_c - first_c, 7);
        chk("stream_peak", peak, LAT);
        for (int i = 0; i < 8 && i < got_n; i++) chk($sformatf("stream_data%0d", i), {16'd0, got[i]}, i);

        apply(1'b0, 1'b1, 1'b1, 16'h0040, 16'h5A5A);
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0, 16'(i * 2), 16'h0);
        apply(1'b1, 1'b1, 1'b1, 16'h0040, 16'hDEAD);
        chk("midrst_outstanding", {28'd0, outstanding}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        apply(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
        idle(LAT - 1);
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_rst_data", {16'd0, rsp_data}, 32'h5A5A);
        idle(3);

        for (int i = 0; i < 32; i++) apply(1'b0, 1'b1, 1'b1, 16'(i * 2), 16'($urandom));
        idle(6);
        for (int i = 0; i < 600; i++) begin
            widx  = $urandom_range(0, 31);
            waddr = (16'($urandom) & 16'hF800) | 16'(widx << 1) | 16'($urandom_range(0, 1));
            apply($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, waddr, 16'($urandom));
        end
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
